// File: rtl/mem_bus_pkg.sv
// Shared types and width helpers for the memory bus arbiter.
// The lock FSM state type is only used when MEM_ARB_LOCK_EN is defined.
package mem_bus_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } lock_state_t;

   function automatic int be_width(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/rr_grant.sv
// Rotating-priority one-hot grant: scans req upward from ptr with wrap and
// grants the first set bit. Reusable for any round-robin arbiter.
module rr_grant #(
   parameter int N     = 2,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [PTR_W-1:0] gnt_idx,
   output logic             gnt_any
);

   int unsigned j;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      j       = 0;
      for (int i = 0; i < N; i++) begin
         j = (int'(ptr) + i) % N;
         if (!gnt_any && req[j]) begin
            gnt[j]  = 1'b1;
            gnt_idx = PTR_W'(j);
            gnt_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// N-port round-robin arbiter onto one synchronous byte-enabled memory bus,
// with a 1-cycle registered response. Define MEM_ARB_LOCK_EN for bus locking.
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter  int NUM_PORTS = 2,
   parameter  int ADDR_W    = ADDR_W_DEF,
   parameter  int DATA_W    = DATA_W_DEF,
   localparam int BE_W      = be_width(DATA_W)
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [NUM_PORTS-1:0]        req_valid,
   output logic [NUM_PORTS-1:0]        req_ready,
   input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
   input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
   input  logic [NUM_PORTS*BE_W-1:0]   req_be,
   input  logic [NUM_PORTS-1:0]        req_we,
   input  logic [NUM_PORTS-1:0]        req_lock,
   output logic [NUM_PORTS-1:0]        resp_valid,
   output logic [DATA_W-1:0]           resp_rdata,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_data_i,
   output logic [BE_W-1:0]             mem_data_en,
   output logic                        mem_write_en,
   input  logic [DATA_W-1:0]           mem_data_o
);

   localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   logic [NUM_PORTS-1:0] eligible;
   logic [NUM_PORTS-1:0] req_in;
   logic [NUM_PORTS-1:0] gnt;
   logic [PTR_W-1:0]     gnt_idx;
   logic                 gnt_any;
   logic                 advance;
   logic [PTR_W-1:0]     rr_ptr;
   logic [PTR_W-1:0]     rr_ptr_nxt;

   logic                 pend_vld_p1;
   logic [PTR_W-1:0]     pend_port_p1;
   logic                 pend_we_p1;

`ifdef MEM_ARB_LOCK_EN
   lock_state_t      state, state_nxt;
   logic [PTR_W-1:0] owner, owner_nxt;

   // While locked only the owner may be granted; the pointer is frozen.
   always_comb begin
      eligible = req_valid;
      if (state == LOCKED)
         eligible = req_valid & (NUM_PORTS'(1) << owner);
   end

   assign advance = gnt_any && (state == ARB);

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      case (state)
         ARB: begin
            if (gnt_any && req_lock[gnt_idx]) begin
               state_nxt = LOCKED;
               owner_nxt = gnt_idx;
            end
         end
         LOCKED: begin
            if (!req_lock[owner])
               state_nxt = ARB;
         end
         default: state_nxt = ARB;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ARB;
         owner <= '0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
      end
   end
`else
   logic unused_lock;

   assign unused_lock = ^req_lock;
   assign eligible    = req_valid;
   assign advance     = gnt_any;
`endif

   // Nothing is accepted while reset is asserted.
   assign req_in = eligible & {NUM_PORTS{reset_n}};

   rr_grant #(
      .N     (NUM_PORTS),
      .PTR_W (PTR_W)
   ) u_rr_grant (
      .req     (req_in),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   assign req_ready  = gnt;
   assign rr_ptr_nxt = (gnt_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;

   // Stage p0: granted request drives the bus combinationally.
   always_comb begin
      mem_addr     = '0;
      mem_data_i   = '0;
      mem_data_en  = '0;
      mem_write_en = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (gnt[i]) begin
            mem_addr     = req_addr[i*ADDR_W +: ADDR_W];
            mem_data_i   = req_wdata[i*DATA_W +: DATA_W];
            mem_data_en  = req_be[i*BE_W +: BE_W];
            mem_write_en = req_we[i];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr      <= '0;
         pend_vld_p1 <= 1'b0;
      end else begin
         pend_vld_p1 <= gnt_any;
         if (advance)
            rr_ptr <= rr_ptr_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (gnt_any) begin
         pend_port_p1 <= gnt_idx;
         pend_we_p1   <= req_we[gnt_idx];
      end
   end

   // Stage p1: response strobe and read data one cycle after acceptance.
   assign resp_valid = pend_vld_p1 ? (NUM_PORTS'(1) << pend_port_p1) : '0;
   assign resp_rdata = (pend_vld_p1 && !pend_we_p1) ? mem_data_o : '0;

endmodule
